// File: rtl/uart_rx_fifo_if.sv
// Byte-source handshake between the UART receiver and its consumer.
// The master modport is the receiver side.
interface uart_rx_fifo_if;
  logic       RX;
  logic       clr_rdy;
  logic       rdy;
  logic [7:0] rx_data;
  logic       framing_err;
  logic       overrun;

  modport master (
    input  RX,
    input  clr_rdy,
    output rdy,
    output rx_data,
    output framing_err,
    output overrun
  );

  modport slave (
    output RX,
    output clr_rdy,
    input  rdy,
    input  rx_data,
    input  framing_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a small FIFO.
// The FIFO presents a rdy / rx_data / clr_rdy pop handshake.
module uart_rx_fifo #(
  parameter int BAUD_DIV = 2604,
  parameter int DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.master bus
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          r_rx_meta, r_rx_sync, r_rx_prev, r_armed;
  logic [1:0]    r_settle;
  logic [1:0]    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [NW-1:0] r_count;
  logic          r_framing_err, r_overrun;

  logic w_fall, w_tick, w_stop_eval, w_push, w_full, w_empty, w_pop, w_wr;

  // Edge detection only arms after the line has been seen idle following reset,
  // so a reset released mid-frame cannot start a false frame on a low line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_settle  <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= bus.RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (r_settle != 2'd3)
        r_settle <= r_settle + 2'd1;
      else if (r_rx_sync)
        r_armed <= 1'b1;
    end
  end

  assign w_fall      = r_armed & r_rx_prev & ~r_rx_sync;
  assign w_tick      = (r_baud_cnt == '0);
  assign w_stop_eval = (r_state == S_STOP) & w_tick;
  assign w_push      = w_stop_eval & r_rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_baud_cnt <= BAUD_HALF;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else if (!r_rx_sync) begin
            r_baud_cnt <= BAUD_FULL;
            r_bit_cnt  <= 4'd0;
            r_state    <= S_DATA;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_shift    <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            r_baud_cnt <= BAUD_FULL;
            if (r_bit_cnt == 4'd7)
              r_state <= S_STOP;
          end
        end
        default: begin
          if (!w_tick)
            r_baud_cnt <= r_baud_cnt - 1'b1;
          else
            r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.clr_rdy & ~w_empty;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_framing_err <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= 8'h00;
    end else begin
      r_framing_err <= w_stop_eval & ~r_rx_sync;
      r_overrun     <= w_push & ~w_wr;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.rdy         = ~w_empty;
  assign bus.rx_data     = r_mem[r_rd_ptr];
  assign bus.framing_err = r_framing_err;
  assign bus.overrun     = r_overrun;

endmodule
